// File: rtl/stopwatch_key_ctrl.sv
// PS/2 set-2 scan-code decoder that drives the stopwatch up/go/clr controls.
// Optional macro STOPWATCH_CLR_PAUSE_EN: an accepted clear key also pauses the count.
module stopwatch_key_ctrl #(
  parameter logic [7:0] KEY_GO      = 8'h34,
  parameter logic [7:0] KEY_STOP    = 8'h1B,
  parameter logic [7:0] KEY_TOG     = 8'h29,
  parameter logic [7:0] KEY_CLR     = 8'h21,
  parameter logic [7:0] KEY_UP      = 8'h3C,
  parameter logic [7:0] KEY_DN      = 8'h23,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       up,
  output logic       go,
  output logic       clr,
  output logic       seq_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t           state_q;
  logic [7:0]       held_q;
  logic             held_vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_q, go_q, clr_q, seq_err_q;
  logic             in_seq, timeout;

  // The counter only runs while a prefix is pending; any byte restarts it.
  always_comb begin
    in_seq  = (state_q != S_IDLE);
    timeout = in_seq && !rx_done_tick && (cnt_q == CNT_MAX);
    cnt_d   = '0;
    if (in_seq && !rx_done_tick && !timeout) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      cnt_q      <= '0;
      up_q       <= 1'b1;
      go_q       <= 1'b0;
      clr_q      <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      clr_q     <= 1'b0;
      seq_err_q <= 1'b0;
      cnt_q     <= cnt_d;
      if (timeout) begin
        state_q    <= S_IDLE;
        seq_err_q  <= 1'b1;
        held_vld_q <= 1'b0;
      end else if (rx_done_tick) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == CODE_BRK) begin
              state_q <= S_BRK;
            end else if (rx_data == CODE_EXT) begin
              state_q <= S_EXT;
            end else if (!(held_vld_q && (rx_data == held_q))) begin
              // New make code (typematic repeats of the held key fall through).
              held_q     <= rx_data;
              held_vld_q <= 1'b1;
              if (rx_data == KEY_GO) begin
                go_q <= 1'b1;
              end else if (rx_data == KEY_STOP) begin
                go_q <= 1'b0;
              end else if (rx_data == KEY_TOG) begin
                go_q <= ~go_q;
              end else if (rx_data == KEY_CLR) begin
                clr_q <= 1'b1;
`ifdef STOPWATCH_CLR_PAUSE_EN
                go_q  <= 1'b0;
`endif
              end else if (rx_data == KEY_UP) begin
                up_q <= 1'b1;
              end else if (rx_data == KEY_DN) begin
                up_q <= 1'b0;
              end
            end
          end
          S_BRK: begin
            state_q <= S_IDLE;
            if (rx_data == held_q) held_vld_q <= 1'b0;
          end
          S_EXT: begin
            state_q <= (rx_data == CODE_BRK) ? S_EXT_BRK : S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign up      = up_q;
  assign go      = go_q;
  assign clr     = clr_q;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl: vector table plus timeout/reset sequences.
module tb_stopwatch_key_ctrl;

  localparam int TO = 16;
`ifdef STOPWATCH_CLR_PAUSE_EN
  localparam logic GC = 1'b0;
`else
  localparam logic GC = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       up, go, clr, seq_err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       up;
    logic       go;
    logic       clr;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  stopwatch_key_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .up(up), .go(go), .clr(clr), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic t, logic [7:0] d, logic u, logic g, logic c, logic e);
    vec_t v;
    v.tick = t; v.data = d; v.up = u; v.go = g; v.clr = c; v.err = e;
    return v;
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic u, logic g, logic c, logic e);
    chk({tag, ".up"}, up, u);
    chk({tag, ".go"}, go, g);
    chk({tag, ".clr"}, clr, c);
    chk({tag, ".seq_err"}, seq_err, e);
  endtask

  // One clock cycle with the given input; outputs sampled 1 time unit after the edge.
  task automatic cyc(logic t, logic [7:0] d);
    rx_done_tick = t;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
  endtask

  initial begin
    // make/break, toggle with typematic repeats
    tbl.push_back(mk(1, 8'h34, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h34, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h1B, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h1B, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 0, 0, 0));
    // clear while running
    tbl.push_back(mk(1, 8'hF0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h29, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h34, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8'h21, 1, GC, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'h21, 1, GC, 0, 0));
    // extended codes ignored, then plain D and rollover U -> D
    tbl.push_back(mk(1, 8'hE0, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'h23, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'hE0, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'hF0, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'h23, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'h23, 0, GC, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 1, GC, 0, 0));
    tbl.push_back(mk(1, 8'h23, 0, GC, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].tick, tbl[i].data);
      chk_all($sformatf("vec%0d", i), tbl[i].up, tbl[i].go, tbl[i].clr, tbl[i].err);
    end

    // Timeout inside a break prefix: seq_err after TO idle cycles, exactly once.
    cyc(1, 8'hF0);
    for (int k = 1; k <= TO + 1; k++) begin
      cyc(0, 8'h00);
      chk($sformatf("to_err%0d", k), seq_err, (k == TO));
    end
    cyc(1, 8'h3C);
    chk_all("after_to_3C", 1, GC, 0, 0);

    // Byte arriving in the timeout cycle wins: no seq_err, processed as break.
    cyc(1, 8'hF0);
    for (int k = 1; k < TO; k++) cyc(0, 8'h00);
    cyc(1, 8'h23);
    chk_all("race_tick", 1, GC, 0, 0);
    cyc(0, 8'h00);
    chk_all("race_next", 1, GC, 0, 0);
    cyc(1, 8'h23);
    chk_all("race_make23", 0, GC, 0, 0);

    // Asynchronous reset while in EXT_BRK with go=1, up=0.
    cyc(1, 8'h34);
    chk_all("pre_rst_go", 0, 1, 0, 0);
    cyc(1, 8'hE0);
    cyc(1, 8'hF0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 8'hF0);
    chk_all("rst_f0", 1, 0, 0, 0);
    cyc(1, 8'h34);
    chk_all("rst_brk34", 1, 0, 0, 0);
    cyc(0, 8'h00);
    chk_all("rst_idle", 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Clear must never be high on two consecutive edges.
  logic clr_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (clr && clr_prev) begin
      n_checks++;
      n_fail++;
      $display("FAIL clr_consecutive: got 1 twice expected single pulse");
    end
    clr_prev = clr;
  end

endmodule
